app_byte_unpacker: RTL and testbench

Application-side engine between the two block RAMs of the SPI bridge. It reads a block of 32-bit words from the SPI-written input BRAM (32-bit read port) and unpacks each word into four bytes, least-significant byte first. It writes those bytes into the output BRAM (8-bit write port) that the SPI slave later shifts back out, then writes an 8-bit additive checksum byte. It runs on the application clock and is started and monitored by the controller.

---
 rtl/app_byte_unpacker.sv | 160 ++++++++++++++++
 tb/tb_app_byte_unpacker.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/app_byte_unpacker.sv
// Reads 32-bit words from the input BRAM and writes them LSB-first as bytes to the output BRAM, followed by an additive checksum byte.
// Latency: RD_LATENCY+5 cycles per word, plus 2 cycles (checksum write, done); done arrives N*(RD_LATENCY+5)+2 cycles after start.
// Backpressure: none; both BRAMs accept one access per cycle, and start is ignored while busy.
module app_byte_unpacker #(
    parameter int RD_LATENCY = 2
) (
    input  logic        appclk,
    input  logic        rstb,
    input  logic        start,
    input  logic [10:0] word_count,
    input  logic [9:0]  rd_base,
    input  logic [11:0] wr_base,
    input  logic [31:0] wr_do,
    output logic [9:0]  wr_rdaddr,
    output logic        wr_rden,
    output logic [7:0]  rd_di,
    output logic [11:0] rd_wraddr,
    output logic        rd_wren,
    output logic        rd_we,
    output logic        busy,
    output logic        done,
    output logic [7:0]  checksum
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_UNPACK,
        S_CSUM,
        S_DONE
    } state_t;

    localparam logic [2:0]  WAIT_LAST = 3'(RD_LATENCY - 1);
    localparam logic [10:0] MAX_WORDS = 11'd1024;

    state_t      state;
    state_t      state_nxt;
    logic [9:0]  rd_addr;
    logic [11:0] wr_addr;
    logic [10:0] words_left;
    logic [2:0]  wait_cnt;
    logic [1:0]  byte_idx;
    logic [31:0] word_q;
    logic [7:0]  csum;
    logic [7:0]  cur_byte;
    logic [10:0] count_clamped;
    logic        last_byte;

    assign count_clamped = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;
    assign last_byte     = (byte_idx == 2'd3);

    always_comb begin
        cur_byte = word_q[7:0];
        case (byte_idx)
            2'd0: cur_byte = word_q[7:0];
            2'd1: cur_byte = word_q[15:8];
            2'd2: cur_byte = word_q[23:16];
            2'd3: cur_byte = word_q[31:24];
            default: cur_byte = word_q[7:0];
        endcase
    end

    always_ff @(posedge appclk or negedge rstb) begin
        if (!rstb) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (count_clamped == 11'd0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: state_nxt = S_WAIT;
            S_WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    state_nxt = S_UNPACK;
                end
            end
            S_UNPACK: begin
                if (last_byte) begin
                    state_nxt = (words_left == 11'd1) ? S_CSUM : S_FETCH;
                end
            end
            S_CSUM:  state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Address counters wrap naturally at their widths (1024 words in, 4096 bytes out).
    always_ff @(posedge appclk or negedge rstb) begin
        if (!rstb) begin
            rd_addr    <= '0;
            wr_addr    <= '0;
            words_left <= '0;
            wait_cnt   <= '0;
            byte_idx   <= '0;
            word_q     <= '0;
            csum       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        rd_addr    <= rd_base;
                        wr_addr    <= wr_base;
                        words_left <= count_clamped;
                        csum       <= '0;
                    end
                end
                S_FETCH: begin
                    wait_cnt <= '0;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + 3'd1;
                    if (wait_cnt == WAIT_LAST) begin
                        word_q   <= wr_do;
                        byte_idx <= '0;
                    end
                end
                S_UNPACK: begin
                    wr_addr  <= wr_addr + 12'd1;
                    csum     <= csum + cur_byte;
                    byte_idx <= byte_idx + 2'd1;
                    if (last_byte) begin
                        rd_addr    <= rd_addr + 10'd1;
                        words_left <= words_left - 11'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decode straight from registered state, so reset clears them without waiting for a clock.
    always_comb begin
        wr_rden   = (state == S_FETCH);
        wr_rdaddr = rd_addr;
        rd_wren   = (state == S_UNPACK) || (state == S_CSUM);
        rd_we     = rd_wren;
        rd_wraddr = wr_addr;
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        checksum  = csum;
        rd_di     = 8'h00;
        if (state == S_UNPACK) begin
            rd_di = cur_byte;
        end else if (state == S_CSUM) begin
            rd_di = csum;
        end
    end

endmodule

// File: tb/tb_app_byte_unpacker.sv
// Bench for app_byte_unpacker: behavioural BRAMs, write/read scoreboards, vector table plus abort/restart sequences.
module tb_app_byte_unpacker;

    localparam int RD_LAT = 2;

    logic        appclk = 1'b0;
    logic        rstb   = 1'b0;
    logic        start  = 1'b0;
    logic [10:0] word_count = '0;
    logic [9:0]  rd_base = '0;
    logic [11:0] wr_base = '0;
    logic [31:0] wr_do;
    logic [9:0]  wr_rdaddr;
    logic        wr_rden;
    logic [7:0]  rd_di;
    logic [11:0] rd_wraddr;
    logic        rd_wren;
    logic        rd_we;
    logic        busy;
    logic        done;
    logic [7:0]  checksum;

    app_byte_unpacker #(.RD_LATENCY(RD_LAT)) dut (
        .appclk     (appclk),
        .rstb       (rstb),
        .start      (start),
        .word_count (word_count),
        .rd_base    (rd_base),
        .wr_base    (wr_base),
        .wr_do      (wr_do),
        .wr_rdaddr  (wr_rdaddr),
        .wr_rden    (wr_rden),
        .rd_di      (rd_di),
        .rd_wraddr  (rd_wraddr),
        .rd_wren    (rd_wren),
        .rd_we      (rd_we),
        .busy       (busy),
        .done       (done),
        .checksum   (checksum)
    );

    always #5 appclk = ~appclk;

    int cyc = 0;
    always @(posedge appclk) cyc <= cyc + 1;

    // Input BRAM: data valid RD_LAT cycles after rden; garbage otherwise so mistimed captures show up.
    logic [31:0] in_mem [1024];
    logic [31:0] rd_pipe [RD_LAT];
    always @(posedge appclk) begin
        rd_pipe[0] <= wr_rden ? in_mem[wr_rdaddr] : 32'hDEADBEEF;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign wr_do = rd_pipe[RD_LAT-1];

    typedef struct packed {
        logic [11:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t         exp_wr[$];
    logic [9:0]  exp_rd[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge appclk) begin
        if (rd_wren || rd_we) begin
            chk("we_equals_wren", 64'(rd_we), 64'(rd_wren));
            if (exp_wr.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL stray_write: got %h@%h, expected no write", rd_di, rd_wraddr);
            end else begin
                wr_t e;
                e = exp_wr.pop_front();
                chk("wr_addr", 64'(rd_wraddr), 64'(e.addr));
                chk("wr_data", 64'(rd_di), 64'(e.data));
            end
        end
        if (wr_rden) begin
            if (exp_rd.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL stray_read: got read @%h, expected no read", wr_rdaddr);
            end else begin
                logic [9:0] a;
                a = exp_rd.pop_front();
                chk("rd_addr", 64'(wr_rdaddr), 64'(a));
            end
        end
    end

    task automatic run_vec(input string name, input logic [9:0] rb, input logic [11:0] wb,
                           input logic [10:0] cnt, input logic [31:0] w0, input logic [31:0] w1,
                           input bit csum_known, input logic [7:0] csum_tab, input int done_exp,
                           input int restart_at);
        logic [9:0]  ra;
        logic [11:0] wa;
        logic [7:0]  sum;
        logic [7:0]  csum_exp;
        logic [31:0] w;
        int          n;
        int          t0;
        int          dcyc;
        int          nbusy;
        int          late_busy;
        bit          got;
        in_mem[rb] = w0;
        in_mem[rb + 10'd1] = w1;
        ra = rb;
        wa = wb;
        sum = 8'h00;
        n = (cnt > 11'd1024) ? 1024 : int'(cnt);
        for (int i = 0; i < n; i++) begin
            exp_rd.push_back(ra);
            w = in_mem[ra];
            for (int k = 0; k < 4; k++) begin
                exp_wr.push_back({wa, w[8*k +: 8]});
                sum = sum + w[8*k +: 8];
                wa = wa + 12'd1;
            end
            ra = ra + 10'd1;
        end
        if (n > 0) exp_wr.push_back({wa, sum});
        csum_exp = csum_known ? csum_tab : sum;

        @(posedge appclk); #1;
        rd_base = rb;
        wr_base = wb;
        word_count = cnt;
        start = 1'b1;
        t0 = cyc;
        got = 0;
        nbusy = 0;
        dcyc = -1;
        for (int k = 0; k < 10000 && !got; k++) begin
            @(posedge appclk); #1;
            start = ((cyc - t0) == restart_at);
            @(negedge appclk);
            if (busy) nbusy++;
            if (done) begin
                got = 1;
                dcyc = cyc - t0;
            end
        end
        start = 1'b0;
        chk({name, "_done_cycle"}, 64'(dcyc), 64'(done_exp));
        chk({name, "_busy_cycles"}, 64'(nbusy), 64'(done_exp));
        chk({name, "_checksum"}, 64'(checksum), 64'(csum_exp));
        late_busy = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge appclk); #1;
            if (busy) late_busy++;
        end
        chk({name, "_idle_after_done"}, 64'(late_busy), 64'd0);
        chk({name, "_checksum_hold"}, 64'(checksum), 64'(csum_exp));
        chk({name, "_writes_left"}, 64'(exp_wr.size()), 64'd0);
        chk({name, "_reads_left"}, 64'(exp_rd.size()), 64'd0);
        exp_wr.delete();
        exp_rd.delete();
    endtask

    typedef struct {
        string       name;
        logic [9:0]  rb;
        logic [11:0] wb;
        logic [10:0] cnt;
        logic [31:0] w0;
        logic [31:0] w1;
        bit          ck;
        logic [7:0]  cs;
        int          dn;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{"n1_basic", 10'h000, 12'h010, 11'd1,    32'h44332211, 32'h0,        1'b1, 8'hAA, 9};
        vecs[1] = '{"wrap",     10'h3FF, 12'hFFE, 11'd2,    32'h04030201, 32'h08070605, 1'b1, 8'h24, 16};
        vecs[2] = '{"csum_ovf", 10'h100, 12'h200, 11'd2,    32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 8'hF8, 16};
        vecs[3] = '{"zero",     10'h050, 12'h300, 11'd0,    32'h12345678, 32'h0,        1'b1, 8'h00, 1};
        vecs[4] = '{"n1_mixed", 10'h2A0, 12'h7FC, 11'd1,    32'h80FF7F01, 32'h0,        1'b1, 8'hFF, 9};
        vecs[5] = '{"n3",       10'h123, 12'h456, 11'd3,    32'hCAFEF00D, 32'h13579BDF, 1'b0, 8'h00, 23};
        vecs[6] = '{"clamp",    10'h3F0, 12'hF00, 11'd2000, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 8'h00, 7170};

        for (int i = 0; i < 1024; i++) in_mem[i] = 32'(i) * 32'h9E3779B1;

        #12;
        chk("reset_outputs", {wr_rdaddr, wr_rden, rd_di, rd_wraddr, rd_wren, rd_we, busy, done, checksum}, 64'd0);
        @(negedge appclk);
        rstb = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i].name, vecs[i].rb, vecs[i].wb, vecs[i].cnt, vecs[i].w0, vecs[i].w1,
                    vecs[i].ck, vecs[i].cs, vecs[i].dn, -1);
        end

        // start pulsed during UNPACK byte 1 of the only word must not alter or extend the run
        run_vec("restart_ignored", 10'h000, 12'h010, 11'd1, 32'h44332211, 32'h0, 1'b1, 8'hAA, 9, 5);

        // reset asserted during UNPACK byte 2: bytes 0 and 1 land, nothing after
        in_mem[0] = 32'h44332211;
        exp_rd.push_back(10'h000);
        exp_wr.push_back({12'h010, 8'h11});
        exp_wr.push_back({12'h011, 8'h22});
        @(posedge appclk); #1;
        rd_base = 10'h000;
        wr_base = 12'h010;
        word_count = 11'd1;
        start = 1'b1;
        @(posedge appclk); #1;
        start = 1'b0;
        repeat (5) @(posedge appclk);
        #2;
        rstb = 1'b0;
        #1;
        chk("abort_outputs_zero", {wr_rdaddr, wr_rden, rd_di, rd_wraddr, rd_wren, rd_we, busy, done, checksum}, 64'd0);
        chk("abort_writes_before", 64'(exp_wr.size()), 64'd0);
        chk("abort_reads_before", 64'(exp_rd.size()), 64'd0);
        repeat (2) @(posedge appclk);
        #3;
        chk("abort_held_zero", {wr_rden, rd_wren, busy, done, checksum}, 64'd0);
        rstb = 1'b1;
        exp_wr.delete();
        exp_rd.delete();

        run_vec("after_reset", 10'h000, 12'h010, 11'd1, 32'h44332211, 32'h0, 1'b1, 8'hAA, 9, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
